// File: rtl/lsu_issue_rx.sv
// LSU end of the issue channel: accepts one load/store at a time, runs a single
// outstanding data-memory transaction and returns load data, store ack or an exception.
module lsu_issue_rx (
    input  logic        clk,
    input  logic        rst,
    input  logic        m_valid,
    input  logic        m_is_store,
    input  logic [2:0]  m_funct3,
    input  logic [4:0]  m_rd,
    input  logic [31:0] m_pc,
    input  logic [31:0] m_addr_base,
    input  logic [31:0] m_store_data,
    output logic        s_stall_from_lsu,
    input  logic        flush,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_req_we,
    output logic [31:0] dmem_req_addr,
    output logic [3:0]  dmem_req_be,
    output logic [31:0] dmem_req_wdata,
    input  logic        dmem_rsp_valid,
    input  logic        dmem_rsp_err,
    input  logic [31:0] dmem_rsp_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [31:0] wb_pc,
    output logic        exc_valid,
    output logic [3:0]  exc_cause,
    output logic [31:0] exc_tval
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // funct3[1:0] selects the access size; 011/110/111 fall into the word bucket.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic mis;
        case (f3[1:0])
            2'b00:   mis = 1'b0;
            2'b01:   mis = a[0];
            default: mis = (a != 2'b00);
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] calc_be(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << a;
            2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] calc_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3[1:0])
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] v;
        sh = word >> {a, 3'b000};
        case (f3[1:0])
            2'b00:   v = f3[2] ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'b01:   v = f3[2] ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: v = word;
        endcase
        return v;
    endfunction

    state_t      r_state;
    state_t      w_next;
    logic        r_stall;
    logic        r_killed;
    logic        r_is_store;
    logic [2:0]  r_funct3;
    logic [4:0]  r_rd;
    logic [31:0] r_pc;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic        r_exc;
    logic [3:0]  r_cause;
    logic [31:0] r_wb_data;

    logic w_accept;
    logic w_misalign;
    logic w_req;
    logic w_done_live;

    assign w_accept   = (r_state == ST_IDLE) && m_valid && !flush;
    assign w_misalign = is_misaligned(m_funct3, m_addr_base[1:0]);

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = w_misalign ? ST_DONE : ST_REQ;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (dmem_req_ready) begin
                    w_next = ST_WAIT;
                end else if (flush) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (dmem_rsp_valid) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_WAIT;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // State, stall and kill tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_stall  <= 1'b0;
            r_killed <= 1'b0;
        end else begin
            r_state <= w_next;
            r_stall <= (w_next != ST_IDLE);
            if (w_accept) begin
                r_killed <= 1'b0;
            end else if (flush && (((r_state == ST_REQ) && dmem_req_ready) || (r_state == ST_WAIT))) begin
                r_killed <= 1'b1;
            end else begin
                r_killed <= r_killed;
            end
        end
    end

    // Operation capture at accept and result capture at response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_store <= 1'b0;
            r_funct3   <= 3'd0;
            r_rd       <= 5'd0;
            r_pc       <= 32'd0;
            r_addr     <= 32'd0;
            r_be       <= 4'd0;
            r_wdata    <= 32'd0;
            r_exc      <= 1'b0;
            r_cause    <= 4'd0;
            r_wb_data  <= 32'd0;
        end else if (w_accept) begin
            r_is_store <= m_is_store;
            r_funct3   <= m_funct3;
            r_rd       <= m_rd;
            r_pc       <= m_pc;
            r_addr     <= m_addr_base;
            r_be       <= calc_be(m_funct3, m_addr_base[1:0]);
            r_wdata    <= calc_wdata(m_funct3, m_store_data);
            r_exc      <= w_misalign;
            r_cause    <= m_is_store ? 4'd6 : 4'd4;
            r_wb_data  <= 32'd0;
        end else if ((r_state == ST_WAIT) && dmem_rsp_valid) begin
            if (dmem_rsp_err) begin
                r_exc     <= 1'b1;
                r_cause   <= r_is_store ? 4'd7 : 4'd5;
                r_wb_data <= 32'd0;
            end else if (!r_is_store) begin
                r_wb_data <= load_ext(r_funct3, r_addr[1:0], dmem_rsp_rdata);
            end else begin
                r_wb_data <= 32'd0;
            end
        end else begin
            r_wb_data <= r_wb_data;
        end
    end

    assign w_req       = (r_state == ST_REQ);
    assign w_done_live = (r_state == ST_DONE) && !r_killed;

    assign s_stall_from_lsu = r_stall;
    assign dmem_req_valid   = w_req;
    assign dmem_req_we      = w_req && r_is_store;
    assign dmem_req_addr    = {r_addr[31:2], 2'b00};
    assign dmem_req_be      = r_be;
    assign dmem_req_wdata   = r_wdata;
    assign wb_valid         = w_done_live;
    assign wb_we            = w_done_live && !r_exc && !r_is_store && (r_rd != 5'd0);
    assign wb_rd            = r_rd;
    assign wb_data          = r_wb_data;
    assign wb_pc            = r_pc;
    assign exc_valid        = w_done_live && r_exc;
    assign exc_cause        = r_cause;
    assign exc_tval         = r_addr;

endmodule
